// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Program-counter and fetch-control stage for the single-cycle processor.
// Holds the architectural PC, presents it as the instruction-memory address,
// forwards the combinationally returned instruction with a valid qualifier and
// selects the next PC (sequential, redirect, stall). Illegal fetch targets
// (misaligned or beyond the end of instruction memory) freeze the stage in a
// sticky trap state that only reset clears. A free-running counter of
// consumed instructions is kept for debug.
//
// Parameters:
//   RESET_PC    PC loaded on reset (word-aligned, inside memory)
//   IMEM_WORDS  instruction memory depth in 32-bit words
//
// Ports:
//   clk         clock, all state updates on rising edge
//   rst_n       synchronous active-low reset
//   stall       hold PC, current instruction not consumed
//   br_taken    redirect request (wins over stall)
//   br_target   redirect byte address
//   imem_addr   byte address to instruction memory (= pc)
//   imem_inst   instruction returned by memory (combinational)
//   pc          current PC
//   pc_four     pc + 4 (link value)
//   inst        instruction for decode, nop when inst_valid = 0
//   inst_valid  inst is a real fetched instruction
//   trap        sticky fetch exception
//   trap_cause  00 none, 01 misaligned target, 10 out-of-range
//   trap_pc     offending target address
//   fetch_cnt   number of consumed instructions (wraps)
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] pc,
    output logic [31:0] pc_four,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_pc,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
    localparam logic [31:0] LAST_PC    = IMEM_BYTES - 32'd4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_RANGE     = 2'b10;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // -------------------------------------------------------------------------
    // Next-state / next-PC selection
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cause_d   = cause_q;
        trap_pc_d = trap_pc_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_BOOT: begin
                // Single bubble cycle; redirects arriving now are dropped.
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (br_taken) begin
                    if (br_target[1:0] != 2'b00) begin
                        state_d   = ST_TRAP;
                        cause_d   = CAUSE_MISALIGN;
                        trap_pc_d = br_target;
                    end else if (br_target >= IMEM_BYTES) begin
                        state_d   = ST_TRAP;
                        cause_d   = CAUSE_RANGE;
                        trap_pc_d = br_target;
                    end else begin
                        // Legal redirect consumes the current instruction
                        // even when stall is also asserted.
                        pc_d  = br_target;
                        cnt_d = cnt_q + 32'd1;
                    end
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (pc_q == LAST_PC) begin
                    // Last word was consumed; falling off the end traps with
                    // the address that would have been fetched next.
                    state_d   = ST_TRAP;
                    cause_d   = CAUSE_RANGE;
                    trap_pc_d = pc_plus4;
                    cnt_d     = cnt_q + 32'd1;
                end else begin
                    pc_d  = pc_plus4;
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_TRAP: begin
                // Frozen until reset.
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            cause_q   <= CAUSE_NONE;
            trap_pc_q <= 32'h0000_0000;
            cnt_q     <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            trap_pc_q <= trap_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign pc_four    = pc_plus4;
    assign inst_valid = (state_q == ST_RUN);
    assign inst       = inst_valid ? imem_inst : NOP_INST;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign trap_pc    = trap_pc_q;
    assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Table-driven bench for fetch_pc_unit. Each record holds the inputs applied
// for one clock cycle and the outputs expected right after that edge. The
// expected record is queued when its inputs are driven and popped for
// comparison after the edge. A hand-written sequence forces the fetch counter
// next to its wrap point.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic [31:0] inst;
    logic        inst_valid;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        valid;
        logic        trap;
        logic [1:0]  cause;
        logic [31:0] tpc;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    fetch_pc_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (2048)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_addr  (imem_addr),
        .imem_inst  (imem_inst),
        .pc         (pc),
        .pc_four    (pc_four),
        .inst       (inst),
        .inst_valid (inst_valid),
        .trap       (trap),
        .trap_cause (trap_cause),
        .trap_pc    (trap_pc),
        .fetch_cnt  (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: distinct word for every address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    always_comb imem_inst = mem_word(imem_addr);

    function automatic vec_t mk(input logic r, input logic s, input logic b,
                                input logic [31:0] t, input logic [31:0] p,
                                input logic v, input logic tr,
                                input logic [1:0] c, input logic [31:0] tp,
                                input logic [31:0] n);
        vec_t x;
        x.rst_n = r; x.stall = s; x.br = b; x.tgt = t;
        x.pc = p; x.valid = v; x.trap = tr; x.cause = c; x.tpc = tp; x.cnt = n;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst_n     = v.rst_n;
        stall     = v.stall;
        br_taken  = v.br;
        br_target = v.tgt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d pc", idx),         pc,                  e.pc);
        check($sformatf("v%0d imem_addr", idx),  imem_addr,           e.pc);
        check($sformatf("v%0d pc_four", idx),    pc_four,             e.pc + 32'd4);
        check($sformatf("v%0d inst_valid", idx), 32'(inst_valid),     32'(e.valid));
        check($sformatf("v%0d inst", idx),       inst,
              e.valid ? mem_word(e.pc) : 32'h0000_0013);
        check($sformatf("v%0d trap", idx),       32'(trap),           32'(e.trap));
        check($sformatf("v%0d trap_cause", idx), 32'(trap_cause),     32'(e.cause));
        check($sformatf("v%0d trap_pc", idx),    trap_pc,             e.tpc);
        check($sformatf("v%0d fetch_cnt", idx),  fetch_cnt,           e.cnt);
        $display("vec %0d rst_n=%0b stall=%0b br=%0b tgt=%h -> pc=%h valid=%0b trap=%0b cause=%0d tpc=%h cnt=%0d",
                 idx, v.rst_n, v.stall, v.br, v.tgt, pc, inst_valid, trap,
                 trap_cause, trap_pc, fetch_cnt);
    endtask

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;

        //              rst s  b  target         pc             v  tr cause tpc            cnt
        // Reset, boot bubble, sequential fetch, 3-cycle stall.
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         0, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         0, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,         1, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h4,         1, 0, 2'd0, 32'h0,        1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h8,         1, 0, 2'd0, 32'h0,        2));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h8,         1, 0, 2'd0, 32'h0,        2));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h8,         1, 0, 2'd0, 32'h0,        2));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h8,         1, 0, 2'd0, 32'h0,        2));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'hC,         1, 0, 2'd0, 32'h0,        3));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h10,        1, 0, 2'd0, 32'h0,        4));
        // Redirect overrides stall.
        vecs.push_back(mk(1, 1, 1, 32'h40,       32'h40,        1, 0, 2'd0, 32'h0,        5));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h44,        1, 0, 2'd0, 32'h0,        6));
        // Misaligned redirect traps; later branches/stalls ignored.
        vecs.push_back(mk(1, 0, 1, 32'h42,       32'h44,        0, 1, 2'd1, 32'h42,       6));
        vecs.push_back(mk(1, 0, 1, 32'h100,      32'h44,        0, 1, 2'd1, 32'h42,       6));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h44,        0, 1, 2'd1, 32'h42,       6));
        // Reset mid-trap; branch during BOOT is ignored.
        vecs.push_back(mk(0, 0, 1, 32'h80,       32'h0,         0, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 1, 32'h80,       32'h0,         1, 0, 2'd0, 32'h0,        0));
        // Out-of-range redirect to exactly the end of memory.
        vecs.push_back(mk(1, 0, 1, 32'h2000,     32'h0,         0, 1, 2'd2, 32'h2000,     0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         0, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,         1, 0, 2'd0, 32'h0,        0));
        // Run off the end of memory.
        vecs.push_back(mk(1, 0, 1, 32'h1FF8,     32'h1FF8,      1, 0, 2'd0, 32'h0,        1));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h1FF8,      1, 0, 2'd0, 32'h0,        1));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h1FFC,      1, 0, 2'd0, 32'h0,        2));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h1FFC,      1, 0, 2'd0, 32'h0,        2));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h1FFC,      0, 1, 2'd2, 32'h2000,     3));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h1FFC,      0, 1, 2'd2, 32'h2000,     3));
        // Far out-of-range target; misaligned+out-of-range reports misaligned.
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         0, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,         1, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 32'h0,        0, 1, 2'd2, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         0, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,         1, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 1, 32'h2001,     32'h0,         0, 1, 2'd1, 32'h2001,     0));
        // Reset mid-stall.
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,         0, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,         1, 0, 2'd0, 32'h0,        0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h4,         1, 0, 2'd0, 32'h0,        1));
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h4,         1, 0, 2'd0, 32'h0,        1));
        vecs.push_back(mk(0, 1, 0, 32'h0,        32'h0,         0, 0, 2'd0, 32'h0,        0));
        // Leave the stage in RUN at pc=0 with stall held for the wrap test.
        vecs.push_back(mk(1, 1, 0, 32'h0,        32'h0,         1, 0, 2'd0, 32'h0,        0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Fetch counter wrap: preload all-ones between edges, then consume.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        check("wrap preload", fetch_cnt, 32'hFFFF_FFFF);
        apply(mk(1, 0, 0, 32'h0, 32'h4, 1, 0, 2'd0, 32'h0, 32'h0), 100);
        apply(mk(1, 0, 0, 32'h0, 32'h8, 1, 0, 2'd0, 32'h0, 32'h1), 101);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
